// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// multi-cycle MUL/DIV occupancy of EX, plus saturating stall/flush counters.
module hazard_controller #(
    parameter int MULDIV_TIMEOUT = 64,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv_start,
    input  logic             muldiv_done,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             muldiv_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int TW = $clog2(MULDIV_TIMEOUT + 1);

    typedef enum logic {RUN, MULDIV_WAIT} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          load_use;
    logic          branch_flush;

    assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == id_ex_rd)));

    always_comb begin
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        id_ex_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_bubble  = 1'b0;
        muldiv_timeout = 1'b0;
        branch_flush   = 1'b0;
        state_nxt      = state;
        timer_nxt      = timer;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    // A taken branch squashes the ID instruction, so its load-use is moot.
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        branch_flush = 1'b1;
                    end else if (ex_muldiv_start) begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                        state_nxt     = MULDIV_WAIT;
                        timer_nxt     = TW'(1);
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MULDIV_WAIT: begin
                    if (muldiv_done) begin
                        state_nxt = RUN;
                        timer_nxt = '0;
                    end else if (timer == TW'(MULDIV_TIMEOUT)) begin
                        muldiv_timeout = 1'b1;
                        ex_mem_bubble  = 1'b1;
                        state_nxt      = RUN;
                        timer_nxt      = '0;
                    end else begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                        timer_nxt     = timer + TW'(1);
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            timer        <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (!pc_write && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (branch_flush && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: expected control vectors are queued
// as stimulus is applied and popped at the following falling edge.
module tb_hazard_controller;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs1, id_rs2, id_ex_rd;
    logic id_uses_rs1, id_uses_rs2, id_ex_mem_read;
    logic ex_branch_taken, ex_muldiv_start, muldiv_done;

    logic pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush;
    logic ex_mem_bubble, muldiv_timeout;
    logic [31:0] stall_cycles, flush_count;

    logic s_pc_write, s_if_id_write, s_id_ex_write, s_if_id_flush, s_id_ex_flush;
    logic s_ex_mem_bubble, s_muldiv_timeout;
    logic [3:0] s_stall_cycles, s_flush_count;

    always #5 clk = ~clk;

    hazard_controller #(.MULDIV_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
        .muldiv_done(muldiv_done), .pc_write(pc_write),
        .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_bubble(ex_mem_bubble), .muldiv_timeout(muldiv_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    hazard_controller #(.MULDIV_TIMEOUT(8), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
        .muldiv_done(muldiv_done), .pc_write(s_pc_write),
        .if_id_write(s_if_id_write), .id_ex_write(s_id_ex_write),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .ex_mem_bubble(s_ex_mem_bubble), .muldiv_timeout(s_muldiv_timeout),
        .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_bubble, muldiv_timeout}
    logic [6:0] ctrl, s_ctrl;
    assign ctrl   = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
                     ex_mem_bubble, muldiv_timeout};
    assign s_ctrl = {s_pc_write, s_if_id_write, s_id_ex_write, s_if_id_flush,
                     s_id_ex_flush, s_ex_mem_bubble, s_muldiv_timeout};

    localparam logic [6:0] RUNV = 7'b1110000;
    localparam logic [6:0] LUSE = 7'b0010100;
    localparam logic [6:0] BRV  = 7'b1111100;
    localparam logic [6:0] MDW  = 7'b0000010;
    localparam logic [6:0] MDTO = 7'b1110011;
    localparam logic [6:0] RSTV = 7'b0001100;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       ms;
        logic       md;
    } stim_t;

    localparam stim_t IDLE  = '{rs1: 5'd1, rs2: 5'd2, u1: 1'b1, u2: 1'b1, rd: 5'd0,
                                mr: 1'b0, br: 1'b0, ms: 1'b0, md: 1'b0};
    localparam stim_t LD_X5 = '{rs1: 5'd5, rs2: 5'd1, u1: 1'b1, u2: 1'b1, rd: 5'd5,
                                mr: 1'b1, br: 1'b0, ms: 1'b0, md: 1'b0};

    int n_tests = 0;
    int n_fail  = 0;
    logic [6:0] exp_q[$];

    task automatic apply(input stim_t s);
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
        id_ex_rd = s.rd; id_ex_mem_read = s.mr; ex_branch_taken = s.br;
        ex_muldiv_start = s.ms; muldiv_done = s.md;
    endtask

    task automatic do_reset();
        apply(IDLE);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        apply(IDLE);
        reset = 1'b1;
        exp_q.push_back(RSTV);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (ctrl !== e || s_ctrl !== e) begin
            n_fail++; $display("FAIL reset_ctrl got %b/%b want %b", ctrl, s_ctrl, e);
        end
        n_tests++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cycles, flush_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        stim_t st[3];
        logic [6:0] ex[3];
        logic [6:0] e;
        stim_t x0;
        do_reset();
        x0 = IDLE; x0.rd = 5'd0; x0.mr = 1'b1; x0.rs1 = 5'd0;
        st[0] = LD_X5; ex[0] = LUSE;
        st[1] = IDLE;  ex[1] = RUNV;
        st[2] = x0;    ex[2] = RUNV;
        for (int i = 0; i < 3; i++) begin
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (ctrl !== e) begin
                n_fail++; $display("FAIL load_use[%0d] got %b want %b", i, ctrl, e);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (stall_cycles !== 32'd1) begin
            n_fail++; $display("FAIL load_use_stall_cnt got %0d want 1", stall_cycles);
        end
    endtask

    task automatic test_branch();
        stim_t st[3];
        logic [6:0] ex[3];
        logic [6:0] e;
        stim_t br_ld;
        do_reset();
        br_ld = LD_X5; br_ld.br = 1'b1;
        st[0] = br_ld; ex[0] = BRV;
        st[1] = IDLE;  ex[1] = RUNV;
        st[2] = IDLE;  st[2].br = 1'b1; ex[2] = BRV;
        for (int i = 0; i < 3; i++) begin
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (ctrl !== e) begin
                n_fail++; $display("FAIL branch[%0d] got %b want %b", i, ctrl, e);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (flush_count !== 32'd2 || stall_cycles !== 32'd0) begin
            n_fail++; $display("FAIL branch_counts got %0d/%0d want 2/0", flush_count, stall_cycles);
        end
    endtask

    task automatic test_muldiv_done();
        logic [6:0] e;
        stim_t s;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            s = IDLE;
            s.ms = (i == 0);
            s.md = (i == 5) || (i == 7);
            apply(s);
            exp_q.push_back((i < 5) ? MDW : RUNV);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (ctrl !== e) begin
                n_fail++; $display("FAIL muldiv_done[%0d] got %b want %b", i, ctrl, e);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (stall_cycles !== 32'd5) begin
            n_fail++; $display("FAIL muldiv_stall_cnt got %0d want 5", stall_cycles);
        end
    endtask

    task automatic test_muldiv_timeout();
        logic [6:0] e;
        stim_t s;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            s = IDLE;
            s.ms = (i == 0);
            apply(s);
            exp_q.push_back((i < 8) ? MDW : ((i == 8) ? MDTO : RUNV));
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (ctrl !== e || s_ctrl !== e) begin
                n_fail++; $display("FAIL muldiv_timeout[%0d] got %b/%b want %b", i, ctrl, s_ctrl, e);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (stall_cycles !== 32'd8) begin
            n_fail++; $display("FAIL timeout_stall_cnt got %0d want 8", stall_cycles);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [6:0] e;
        stim_t s;
        do_reset();
        s = IDLE; s.ms = 1'b1;
        apply(s);
        @(posedge clk); #1;
        apply(IDLE);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp_q.push_back(RSTV);
        e = exp_q.pop_front();
        n_tests++;
        if (ctrl !== e) begin
            n_fail++; $display("FAIL reset_mid_wait_ctrl got %b want %b", ctrl, e);
        end
        n_tests++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid_wait_cnt got %0d/%0d want 0/0", stall_cycles, flush_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        // done in RUN must be ignored; idle after release must look like RUN
        for (int i = 0; i < 2; i++) begin
            s = IDLE; s.md = (i == 0);
            apply(s); exp_q.push_back(RUNV);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (ctrl !== e) begin
                n_fail++; $display("FAIL after_reset_run[%0d] got %b want %b", i, ctrl, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[4];
        logic [6:0] ex[4];
        logic [6:0] e;
        do_reset();
        st[0] = IDLE;  st[0].br = 1'b1; ex[0] = BRV;
        st[1] = LD_X5; ex[1] = LUSE;
        st[2] = IDLE;  st[2].br = 1'b1; ex[2] = BRV;
        st[3] = IDLE;  st[3].ms = 1'b1; ex[3] = MDW;
        for (int i = 0; i < 4; i++) begin
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (ctrl !== e) begin
                n_fail++; $display("FAIL back_to_back[%0d] got %b want %b", i, ctrl, e);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (flush_count !== 32'd2 || stall_cycles !== 32'd2) begin
            n_fail++; $display("FAIL b2b_counts got %0d/%0d want 2/2", flush_count, stall_cycles);
        end
    endtask

    task automatic test_saturation();
        stim_t s;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(LD_X5);
            @(posedge clk); #1;
        end
        s = IDLE; s.br = 1'b1;
        for (int i = 0; i < 18; i++) begin
            apply(s);
            @(posedge clk); #1;
        end
        apply(IDLE);
        @(negedge clk);
        n_tests++;
        if (s_stall_cycles !== 4'd15 || stall_cycles !== 32'd20) begin
            n_fail++; $display("FAIL stall_saturate got %0d/%0d want 15/20", s_stall_cycles, stall_cycles);
        end
        n_tests++;
        if (s_flush_count !== 4'd15 || flush_count !== 32'd18) begin
            n_fail++; $display("FAIL flush_saturate got %0d/%0d want 15/18", s_flush_count, flush_count);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        apply(IDLE);
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv_done();
        test_muldiv_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
